// File: rtl/vec_load_unit.sv
// Vector unit-stride/strided load: one scalar request per element, packs elements into a VLEN buffer.
// Single outstanding request; buffer is written to the regfile in one beat, done pulses one cycle.
module vec_load_unit #(
  parameter int XLEN    = 32,
  parameter int VLEN    = 512,
  parameter int MDATA_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [XLEN-1:0]    base_addr,
  input  logic [XLEN-1:0]    stride,
  input  logic [1:0]         mop,
  input  logic [2:0]         width,
  input  logic [XLEN-1:0]    vl,
  input  logic [4:0]         vd_addr,
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_addr,
  input  logic               mem_resp_valid,
  input  logic [MDATA_W-1:0] mem_resp_data,
  output logic               wr_en,
  output logic [4:0]         wr_addr,
  output logic [VLEN-1:0]    wr_data,
  output logic               busy,
  output logic               done,
  output logic               illegal
);

  localparam int CW = $clog2(VLEN/8);
  localparam int VW = CW + 1;
  localparam int SW = $clog2(VLEN);
  localparam logic [2:0] W8  = 3'b000;
  localparam logic [2:0] W16 = 3'b101;
  localparam logic [2:0] W32 = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_REQ, S_WAIT, S_WRITE, S_DONE_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   ea_q, ea_d;
  logic [XLEN-1:0]   stride_q, stride_d;
  logic [1:0]        mop_q, mop_d;
  logic [2:0]        width_q, width_d;
  logic [4:0]        vd_q, vd_d;
  logic [VW-1:0]     eff_vl_q, eff_vl_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [VLEN-1:0]   buf_q, buf_d;
  logic              illegal_q, illegal_d;

  logic [VW-1:0]      vlmax_in;
  logic [VW-1:0]      eff_vl_in;
  logic               legal_w;
  logic               misaligned;
  logic [XLEN-1:0]    unit_step;
  logic [XLEN-1:0]    step;
  logic [MDATA_W-1:0] elem_mask;
  logic [MDATA_W-1:0] elem;
  logic [SW-1:0]      shamt;
  logic               last_elem;

  // VLMAX of the incoming EEW, used to clamp vl at capture time
  always_comb begin
    case (width)
      W8:      vlmax_in = VW'(VLEN/8);
      W16:     vlmax_in = VW'(VLEN/16);
      default: vlmax_in = VW'(VLEN/32);
    endcase
    eff_vl_in = (vl < XLEN'(vlmax_in)) ? vl[VW-1:0] : vlmax_in;
  end

  always_comb begin
    legal_w    = 1'b1;
    unit_step  = XLEN'(4);
    misaligned = (ea_q[1:0] != 2'b00);
    elem_mask  = MDATA_W'(32'hFFFF_FFFF);
    shamt      = SW'(cnt_q) << 5;
    case (width_q)
      W8: begin
        unit_step  = XLEN'(1);
        misaligned = 1'b0;
        elem_mask  = MDATA_W'(8'hFF);
        shamt      = SW'(cnt_q) << 3;
      end
      W16: begin
        unit_step  = XLEN'(2);
        misaligned = ea_q[0];
        elem_mask  = MDATA_W'(16'hFFFF);
        shamt      = SW'(cnt_q) << 4;
      end
      W32:     ;
      default: legal_w = 1'b0;
    endcase
  end

  assign step      = (mop_q == 2'b10) ? stride_q : unit_step;
  assign elem      = (mem_resp_data >> {ea_q[1:0], 3'b000}) & elem_mask;
  assign last_elem = ({1'b0, cnt_q} == (eff_vl_q - VW'(1)));

  always_comb begin
    state_d       = state_q;
    ea_d          = ea_q;
    stride_d      = stride_q;
    mop_d         = mop_q;
    width_d       = width_q;
    vd_d          = vd_q;
    eff_vl_d      = eff_vl_q;
    cnt_d         = cnt_q;
    buf_d         = buf_q;
    illegal_d     = illegal_q;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    wr_en         = 1'b0;
    wr_addr       = '0;
    wr_data       = '0;
    done          = 1'b0;
    illegal       = 1'b0;
    busy          = (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CHECK;
          ea_d      = base_addr;
          stride_d  = stride;
          mop_d     = mop;
          width_d   = width;
          vd_d      = vd_addr;
          eff_vl_d  = eff_vl_in;
          cnt_d     = '0;
          buf_d     = '0;
          illegal_d = 1'b0;
        end
      end
      S_CHECK: begin
        if (!legal_w || mop_q[0]) begin
          illegal_d = 1'b1;
          state_d   = S_DONE_ERR;
        end else if (eff_vl_q == '0) begin
          state_d = S_DONE_ERR;
        end else begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (misaligned) begin
          illegal_d = 1'b1;
          buf_d     = '0;
          state_d   = S_DONE_ERR;
        end else begin
          mem_req_valid = 1'b1;
          mem_addr      = {ea_q[XLEN-1:2], 2'b00};
          if (mem_req_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          buf_d = buf_q | (VLEN'(elem) << shamt);
          if (last_elem) begin
            state_d = S_WRITE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            ea_d    = ea_q + step;
            state_d = S_REQ;
          end
        end
      end
      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = vd_q;
        wr_data = buf_q;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_DONE_ERR: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ea_q      <= '0;
      stride_q  <= '0;
      mop_q     <= '0;
      width_q   <= '0;
      vd_q      <= '0;
      eff_vl_q  <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ea_q      <= ea_d;
      stride_q  <= stride_d;
      mop_q     <= mop_d;
      width_q   <= width_d;
      vd_q      <= vd_d;
      eff_vl_q  <= eff_vl_d;
      cnt_q     <= cnt_d;
      buf_q     <= buf_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_vec_load_unit.sv
// Directed bench for vec_load_unit: address scoreboard queue plus a reference packing model.
module tb_vec_load_unit;
  logic         clk = 1'b0;
  logic         reset, start;
  logic [31:0]  base_addr, stride, vl;
  logic [1:0]   mop;
  logic [2:0]   width;
  logic [4:0]   vd_addr;
  logic         mem_req_valid, mem_req_ready;
  logic [31:0]  mem_addr;
  logic         mem_resp_valid;
  logic [31:0]  mem_resp_data;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [511:0] wr_data;
  logic         busy, done, illegal;

  int total  = 0;
  int passed = 0;
  logic [31:0] addr_q[$];

  always #5 clk = ~clk;

  vec_load_unit dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .stride(stride),
    .mop(mop), .width(width), .vl(vl), .vd_addr(vd_addr),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .illegal(illegal)
  );

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic run(input logic [31:0] b, input logic [31:0] s, input logic [1:0] m,
                     input logic [2:0] w, input logic [31:0] n, input logic [4:0] vd,
                     input int stall, input int rst_after, input bit busy_start,
                     input int exp_done_cyc);
    int eew, vlmax, eff, off, nreq, nresp, nwr, ndone, stall_left, post_rst, cyc;
    bit legal, exp_ill, exp_wr, pending, did_rst, stalled;
    logic [31:0] ea, st, word, paddr, hold;
    logic [511:0] exp_vec;
    nreq = 0; nresp = 0; nwr = 0; ndone = 0; post_rst = 0; eff = 0;
    pending = 0; did_rst = 0; stalled = 0; stall_left = stall;
    paddr = 0; hold = 0; exp_vec = '0;
    addr_q.delete();

    eew   = (w == 3'b000) ? 8 : (w == 3'b101) ? 16 : (w == 3'b110) ? 32 : 0;
    legal = (eew != 0) && !m[0];
    exp_ill = !legal;
    if (legal) begin
      vlmax = 512 / eew;
      eff   = (n < 32'(vlmax)) ? int'(n) : vlmax;
      st    = (m == 2'b10) ? s : 32'(eew / 8);
      for (int i = 0; i < eff; i++) begin
        ea = b + 32'(i) * st;
        if ((ea % 32'(eew / 8)) != 0) begin
          exp_ill = 1;
          break;
        end
        addr_q.push_back({ea[31:2], 2'b00});
        off  = int'(ea[1:0]);
        word = memword({ea[31:2], 2'b00});
        for (int k = 0; k < eew; k++) exp_vec[i*eew + k] = word[off*8 + k];
      end
    end
    exp_wr = !exp_ill && (eff > 0) && (rst_after == 0);

    @(negedge clk);
    base_addr = b; stride = s; mop = m; width = w; vl = n; vd_addr = vd;
    start = 1; mem_req_ready = 1; mem_resp_valid = 0;
    for (cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      start = 0;
      if (busy_start && cyc == 5) begin
        start = 1; base_addr = 32'hDEAD_BEE0; stride = 7; vl = 1; vd_addr = ~vd; width = 3'b000;
      end
      if (did_rst) begin
        post_rst++;
        if (post_rst == 1) begin
          chk("busy after reset", busy, 0);
          chk("req_valid after reset", mem_req_valid, 0);
          reset = 0;
        end
      end
      mem_resp_valid = pending;
      mem_resp_data  = pending ? memword(paddr) : $urandom();
      if (pending) nresp++;
      pending = 0;
      if (rst_after > 0 && !did_rst && nresp == rst_after && !mem_resp_valid) begin
        reset = 1; did_rst = 1; mem_req_ready = 0;
      end else begin
        if (stall_left > 0 && (stalled || mem_req_valid)) begin
          mem_req_ready = 0;
          if (!stalled) begin
            stalled = 1; hold = mem_addr;
          end else begin
            chk("stall valid held", mem_req_valid, 1);
            chk("stall addr stable", mem_addr, hold);
          end
          stall_left--;
        end else begin
          mem_req_ready = 1;
        end
        if (mem_req_valid && mem_req_ready) begin
          nreq++;
          if (addr_q.size() > 0) chk("req addr", mem_addr, addr_q.pop_front());
          pending = 1; paddr = mem_addr;
        end
      end
      if (wr_en) begin
        nwr++;
        chk("wr_data", wr_data, exp_vec);
        chk("wr_addr", wr_addr, vd);
      end
      if (done) begin
        ndone++;
        chk("illegal at done", illegal, exp_ill);
        if (exp_done_cyc >= 0) chk("done latency", cyc, exp_done_cyc);
        break;
      end
      if (did_rst && post_rst >= 10) break;
    end
    reset = 0;
    chk("request count", nreq, (rst_after > 0) ? rst_after : eff == 0 ? 0 : exp_ill ? nreq_model(b, st, eew, eff) : eff);
    chk("write count", nwr, exp_wr);
    chk("done count", ndone, (rst_after > 0) ? 0 : 1);
    @(negedge clk);
    mem_resp_valid = 0; start = 0;
    chk("idle after op", busy, 0);
  endtask

  // Number of requests issued before the first misaligned element aborts the load.
  function automatic int nreq_model(input logic [31:0] b, input logic [31:0] st,
                                    input int eew, input int eff);
    logic [31:0] ea;
    for (int i = 0; i < eff; i++) begin
      ea = b + 32'(i) * st;
      if ((ea % 32'(eew / 8)) != 0) return i;
    end
    return eff;
  endfunction

  initial begin
    reset = 1; start = 0; base_addr = 0; stride = 0; vl = 0; mop = 0; width = 0; vd_addr = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset req_valid", mem_req_valid, 0);
    chk("reset wr_en", wr_en, 0);
    chk("reset done", done, 0);
    chk("reset wr_data", wr_data, 0);
    reset = 0;

    run(32'h100, 0, 2'b00, 3'b110, 4, 5'd3, 0, 0, 0, -1);
    run(32'h201, 3, 2'b10, 3'b000, 3, 5'd7, 0, 0, 0, -1);
    run(32'h0, 0, 2'b00, 3'b110, 20, 5'd31, 0, 0, 1, -1);
    run(32'h100, 0, 2'b00, 3'b110, 0, 5'd1, 0, 0, 0, 2);
    run(32'h100, 4, 2'b01, 3'b110, 4, 5'd1, 0, 0, 0, 2);
    run(32'h101, 0, 2'b00, 3'b101, 4, 5'd2, 0, 0, 0, 3);
    run(32'h100, 0, 2'b00, 3'b111, 4, 5'd2, 0, 0, 0, 2);
    run(32'h400, 0, 2'b00, 3'b101, 8, 5'd9, 5, 0, 0, -1);
    run(32'h800, 8, 2'b10, 3'b110, 6, 5'd2, 0, 2, 0, -1);
    run(32'h1000, 32'hFFFF_FFFE, 2'b10, 3'b101, 5, 5'd17, 0, 0, 0, -1);
    run(32'h302, 6, 2'b10, 3'b101, 3, 5'd4, 0, 0, 0, -1);
    run(32'h3, 1, 2'b00, 3'b000, 70, 5'd12, 2, 0, 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
